seq_bank_req_ctrl: RTL

//  Request front-end for the banked synchronous RAM (seq_bank). Accepts valid/ready

---
 rtl/seq_bank_req_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/seq_bank_req_ctrl.sv
// Request front-end for the banked synchronous RAM.
// Issues read/write to the RAM, holds read address, queues read data.
module seq_bank_req_ctrl #(
    parameter int DATA_WIDTH       = 32,
    parameter int BYTE_ADDR_WIDTH  = 8,
    parameter int BANKS_ADDR_WIDTH = 2,
    parameter int RSP_DEPTH        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [BYTE_ADDR_WIDTH+BANKS_ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_en,
    output logic                  mem_wen,
    output logic [BYTE_ADDR_WIDTH+BANKS_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int ADDR_W = BYTE_ADDR_WIDTH + BANKS_ADDR_WIDTH;
    localparam int PTR_W  = $clog2(RSP_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

    typedef enum logic {IDLE, RD_CAPT} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_W-1:0]       addr_hold;
    logic [DATA_WIDTH-1:0]   fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    accept;
    logic                    push;
    logic                    pop;

    // Next state, RAM port drive and request handshake.
    // Outside an accept the RAM sees the held address so the
    // bank output mux keeps selecting the bank being captured.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        mem_en    = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = addr_hold;
        mem_din   = '0;
        unique case (state)
            IDLE: begin
                req_ready = rst_n && (count < DEPTH_C);
                accept    = req_valid && req_ready;
                if (accept) begin
                    mem_en   = 1'b1;
                    mem_wen  = req_wen;
                    mem_addr = req_addr;
                    mem_din  = req_wdata;
                    if (!req_wen) begin
                        state_nxt = RD_CAPT;
                    end
                end
            end
            RD_CAPT: begin
                push      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    assign rsp_valid = (count != '0);
    assign rsp_rdata = fifo_mem[rd_ptr];
    assign pop       = rsp_valid && rsp_ready;

    // FSM state and held request address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_hold <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_hold <= req_addr;
            end
        end
    end

    // Response FIFO: capture RAM data, pop on consumer handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_dout;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
